// File: rtl/cpu_debug_jtag_pkg.sv
// Shared types and constants for the system-side virtual-JTAG debug host.
// Holds the sequencer state set, default widths and the debug slave's IR codes.
package cpu_debug_jtag_pkg;

   localparam int DR_WIDTH_DEF = 38;
   localparam int IR_WIDTH_DEF = 2;

   localparam logic [1:0] IR_MONITOR = 2'd0;
   localparam logic [1:0] IR_TRACE   = 2'd1;
   localparam logic [1:0] IR_BREAK   = 2'd2;
   localparam logic [1:0] IR_DEBUG   = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_F,
      UIR,
      CDR,
      SDR,
      UDR,
      RTI,
      RESP
   } jtag_state_e;

endpackage

// File: rtl/cpu_debug_jtag_tckgen.sv
// Free-running tck divider: tck toggles every TCK_DIV clk cycles.
// rise_evt/fall_evt flag the clk cycle whose edge moves tck 0->1 / 1->0.
module cpu_debug_jtag_tckgen #(
   parameter int TCK_DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   output logic tck,
   output logic rise_evt,
   output logic fall_evt
);

   localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(TCK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          wrap;

   assign wrap     = (cnt_q == DIV_LAST);
   assign rise_evt = wrap & ~tck;
   assign fall_evt = wrap & tck;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         tck   <= 1'b0;
      end else if (wrap) begin
         cnt_q <= '0;
         tck   <= ~tck;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/cpu_debug_jtag_host.sv
// Virtual-JTAG initiator: one IR/DR command in, UIR-CDR-SDR-UDR-RTI sequence out,
// captured tdo bits and slave IR status returned on a response handshake.
module cpu_debug_jtag_host
   import cpu_debug_jtag_pkg::*;
#(
   parameter int DR_WIDTH = DR_WIDTH_DEF,
   parameter int IR_WIDTH = IR_WIDTH_DEF,
   parameter int TCK_DIV  = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                busy,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   input  logic [IR_WIDTH-1:0] vji_ir_out,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   localparam int BW = $clog2(DR_WIDTH + 1);

   jtag_state_e         state_q;
   logic [DR_WIDTH-1:0] shift_q;
   logic [DR_WIDTH-1:0] cap_q;
   logic [IR_WIDTH-1:0] ir_q;
   logic [BW-1:0]       bit_cnt_q;
   logic                rise_evt;
   logic                fall_evt;

   cpu_debug_jtag_tckgen #(
      .TCK_DIV (TCK_DIV)
   ) u_tckgen (
      .clk      (clk),
      .reset_n  (reset_n),
      .tck      (vji_tck),
      .rise_evt (rise_evt),
      .fall_evt (fall_evt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cap_q      <= '0;
         ir_q       <= '0;
         bit_cnt_q  <= '0;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_dr     <= '0;
         rsp_ir_out <= '0;
         busy       <= 1'b0;
         vji_tdi    <= 1'b0;
         vji_ir_in  <= '0;
         vji_uir    <= 1'b0;
         vji_cdr    <= 1'b0;
         vji_sdr    <= 1'b0;
         vji_udr    <= 1'b0;
         vji_rti    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  shift_q   <= cmd_dr;
                  ir_q      <= cmd_ir;
                  cap_q     <= '0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state_q   <= WAIT_F;
               end
            end
            WAIT_F: begin
               if (fall_evt) begin
                  vji_ir_in <= ir_q;
                  vji_uir   <= 1'b1;
                  state_q   <= UIR;
               end
            end
            UIR: begin
               if (fall_evt) begin
                  vji_uir <= 1'b0;
                  vji_cdr <= 1'b1;
                  state_q <= CDR;
               end
            end
            CDR: begin
               if (rise_evt)
                  rsp_ir_out <= vji_ir_out;
               if (fall_evt) begin
                  vji_cdr   <= 1'b0;
                  vji_sdr   <= 1'b1;
                  vji_tdi   <= shift_q[0];
                  bit_cnt_q <= '0;
                  state_q   <= SDR;
               end
            end
            SDR: begin
               // Bits are counted on the sampling edge; the fall after the last
               // sample leaves SDR instead of shifting once more.
               if (rise_evt) begin
                  cap_q     <= {vji_tdo, cap_q[DR_WIDTH-1:1]};
                  bit_cnt_q <= bit_cnt_q + BW'(1);
               end
               if (fall_evt) begin
                  if (bit_cnt_q == BW'(DR_WIDTH)) begin
                     vji_sdr <= 1'b0;
                     vji_udr <= 1'b1;
                     vji_tdi <= 1'b0;
                     state_q <= UDR;
                  end else begin
                     shift_q <= shift_q >> 1;
                     vji_tdi <= shift_q[1];
                  end
               end
            end
            UDR: begin
               if (fall_evt) begin
                  vji_udr <= 1'b0;
                  vji_rti <= 1'b1;
                  state_q <= RTI;
               end
            end
            RTI: begin
               if (fall_evt) begin
                  vji_rti   <= 1'b0;
                  rsp_dr    <= cap_q;
                  rsp_valid <= 1'b1;
                  state_q   <= RESP;
               end
            end
            RESP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  vji_ir_in <= '0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
